// File: rtl/data_sram_resp_pkg.sv
// Shared FSM encoding and counter width for the data-SRAM response path.
package data_sram_resp_pkg;

  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/data_sram_resp_dsram_bank.sv
// Single-port synchronous RAM with per-byte write enables and a read register
// that only reloads on a read access.
module dsram_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] index,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  // byte-lane writes; storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // read register holds across writes and idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'h0000_0000;
    end else if (en && (wen == 4'b0000)) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM access block: optional fixed wait-state stall, byte writes,
// registered read data and an out-of-range error pulse.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        err
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cap_wen;
  logic [31:2]      cap_addr;
  logic [31:0]      cap_wdata;

  logic             go;
  logic             oor;
  logic             rd_zero;
  logic [3:0]       acc_wen;
  logic [31:2]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [31:0]      bank_rdata;

  // Select live or captured access and decide whether it completes this cycle.
  always_comb begin
    go        = 1'b0;
    stallreq  = 1'b0;
    acc_wen   = data_sram_wen;
    acc_addr  = data_sram_addr[31:2];
    acc_wdata = data_sram_wdata;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            go = 1'b1;
          end else begin
            stallreq = 1'b1;
          end
        end
      end
      WAIT: begin
        acc_wen   = cap_wen;
        acc_addr  = cap_addr;
        acc_wdata = cap_wdata;
        if (cnt != '0) begin
          stallreq = 1'b1;
        end else begin
          go = 1'b1;
        end
      end
      default: begin
        go = 1'b0;
      end
    endcase
    // reset aborts any pending access, so a captured write never lands
    if (rst) begin
      go       = 1'b0;
      stallreq = 1'b0;
    end
  end

  assign oor = |acc_addr[31:DEPTH_LOG2+2];

  // Control FSM, capture registers, error pulse and out-of-range read flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      err     <= 1'b0;
      rd_zero <= 1'b0;
    end else begin
      err <= go && oor;
      if (go && (acc_wen == 4'b0000)) begin
        rd_zero <= oor;
      end
      case (state)
        IDLE: begin
          if (data_sram_en && (WAIT_CYCLES != 0)) begin
            state     <= WAIT;
            cnt       <= CNT_W'(WAIT_CYCLES - 1);
            cap_wen   <= data_sram_wen;
            cap_addr  <= data_sram_addr[31:2];
            cap_wdata <= data_sram_wdata;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  dsram_bank #(
    .AW(DEPTH_LOG2)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .en   (go && !oor),
    .wen  (acc_wen),
    .index(acc_addr[DEPTH_LOG2+1:2]),
    .wdata(acc_wdata),
    .rdata(bank_rdata)
  );

  // an out-of-range read reads back as zero until the next in-range read
  assign data_sram_rdata = rd_zero ? 32'h0000_0000 : bank_rdata;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench: three instances (0, 2 and 3 wait cycles) driven one at a
// time against a word-array reference model.
module tb_data_sram_resp;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_s    [3];
  logic [3:0]  wen_s   [3];
  logic [31:0] addr_s  [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        stall_s [3];
  logic        err_s   [3];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          sel   = 0;
  exp_t        exp_q [$];
  logic [31:0] mdl [int];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_n0 (
    .clk(clk), .rst(rst), .data_sram_en(en_s[0]), .data_sram_wen(wen_s[0]),
    .data_sram_addr(addr_s[0]), .data_sram_wdata(wdata_s[0]),
    .data_sram_rdata(rdata_s[0]), .stallreq(stall_s[0]), .err(err_s[0]));

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_n2 (
    .clk(clk), .rst(rst), .data_sram_en(en_s[1]), .data_sram_wen(wen_s[1]),
    .data_sram_addr(addr_s[1]), .data_sram_wdata(wdata_s[1]),
    .data_sram_rdata(rdata_s[1]), .stallreq(stall_s[1]), .err(err_s[1]));

  data_sram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_n3 (
    .clk(clk), .rst(rst), .data_sram_en(en_s[2]), .data_sram_wen(wen_s[2]),
    .data_sram_addr(addr_s[2]), .data_sram_wdata(wdata_s[2]),
    .data_sram_rdata(rdata_s[2]), .stallreq(stall_s[2]), .err(err_s[2]));

  function automatic int nwait(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t: got %h, expected %h", name, sel, $time, got, exp);
    end
  endtask

  // Reference model update + expectation push, then drive until accepted.
  task automatic access(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    exp_t        e;
    int          key;
    int          t;
    bit          oor;
    logic [31:0] word;
    oor = (a[31:12] != 20'h0);
    key = k * 1024 + int'({22'h0, a[11:2]});
    if (w == 4'b0000) begin
      last_rd[k] = oor ? 32'h0 : mdl[key];
    end else if (!oor) begin
      word = mdl.exists(key) ? mdl[key] : 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (w[i]) word[8*i +: 8] = d[8*i +: 8];
      end
      mdl[key] = word;
    end
    e.rdata = last_rd[k];
    e.err   = oor;
    e.n     = nwait(k);
    exp_q.push_back(e);
    en_s[k] = 1'b1; wen_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (!stall_s[k]) break;
      t++;
      if (t > 16) begin
        n_cmp++; n_bad++;
        $display("FAIL stall_timeout inst%0d: stallreq still 1 after %0d cycles, expected release", k, t);
        break;
      end
    end
    @(posedge clk); #1;
    en_s[k] = 1'b0;
  endtask

  task automatic idle(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  // Monitor: follows each access through its stall window and checks results.
  initial begin : monitor
    exp_t e;
    int   stall_cnt;
    bit   busy;
    bit   check_next;
    busy = 1'b0; check_next = 1'b0; stall_cnt = 0;
    e.rdata = 32'h0; e.err = 1'b0; e.n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0; check_next = 1'b0;
      end else begin
        if (check_next) begin
          chk("rdata", rdata_s[sel], e.rdata);
          chk("err", 32'(err_s[sel]), 32'(e.err));
          check_next = 1'b0;
        end else begin
          chk("err_idle", 32'(err_s[sel]), 32'h0);
        end
        if (busy) begin
          if (stall_s[sel]) begin
            stall_cnt++;
          end else begin
            chk("stall_cycles", 32'(stall_cnt), 32'(e.n));
            busy = 1'b0; check_next = 1'b1;
          end
        end else if (en_s[sel]) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL queue inst%0d: access seen, got none expected, expected one queued", sel);
          end else begin
            e = exp_q.pop_front();
            if (stall_s[sel]) begin
              stall_cnt = 1; busy = 1'b1;
            end else begin
              stall_cnt = 0;
              chk("stall_cycles", 32'(stall_cnt), 32'(e.n));
              check_next = 1'b1;
            end
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios then randomized traffic per instance.
  initial begin : driver
    logic [31:0] a;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en_s[k] = 1'b0; wen_s[k] = 4'h0; addr_s[k] = 32'h0; wdata_s[k] = 32'h0;
      last_rd[k] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      chk("rst_rdata", rdata_s[k], 32'h0);
      chk("rst_stall", 32'(stall_s[k]), 32'h0);
      chk("rst_err", 32'(err_s[k]), 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    sel = 0;
    access(0, 4'hF, 32'h10, 32'h1234_5678);
    access(0, 4'h0, 32'h10, 32'h0);
    access(0, 4'h5, 32'h10, 32'hAABB_CCDD);
    access(0, 4'h0, 32'h10, 32'h0);
    access(0, 4'hF, 32'h00, 32'hCAFE_F00D);
    access(0, 4'h0, 32'h0001_0000, 32'h0);
    access(0, 4'hF, 32'h0001_0000, 32'h5555_AAAA);
    access(0, 4'h0, 32'h00, 32'h0);
    idle(2);

    sel = 1;
    access(1, 4'hF, 32'h50, 32'h0000_0005);
    access(1, 4'h0, 32'h50, 32'h0);
    idle(2);

    sel = 2;
    access(2, 4'hF, 32'h20, 32'hDEAD_BEEF);
    idle(1);
    access(2, 4'h0, 32'h20, 32'h0);
    access(2, 4'hF, 32'h40, 32'h0);
    idle(2);
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, n: 3});
    en_s[2] = 1'b1; wen_s[2] = 4'hF; addr_s[2] = 32'h40; wdata_s[2] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b1; en_s[2] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_stall", 32'(stall_s[2]), 32'h0);
    chk("abort_rdata", rdata_s[2], 32'h0);
    chk("abort_err", 32'(err_s[2]), 32'h0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) last_rd[k] = 32'h0;
    access(2, 4'h0, 32'h40, 32'h0);
    idle(2);

    for (int k = 0; k < 3; k++) begin
      sel = k;
      for (int i = 0; i < 8; i++) begin
        access(k, 4'hF, 32'h100 + 32'(i * 4), $urandom);
      end
      for (int i = 0; i < 30; i++) begin
        a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0, 1, 2, 3: access(k, 4'h0, a, 32'h0);
          4, 5, 6:    access(k, 4'($urandom_range(1, 15)), a, $urandom);
          default: begin
            a = $urandom;
            if (a[31:12] == 20'h0) a[31] = 1'b1;
            access(k, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hF, a, $urandom);
          end
        endcase
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
